// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests to instruction memory,
// buffers the returned word and presents it to the F/D pipeline register.
// Requests are never abandoned; redirects that arrive while a request is
// in flight are remembered and the stale data is dropped on completion.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrF,
    output logic [31:0] PcPlus4F,
    output logic        ValidF,
    output logic        FetchBusy
);

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HAVE    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] reqaddr, reqaddr_next;
    logic [31:0] ibuf, ibuf_next;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign target   = PCBranchD & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    // State and datapath registers; reset takes effect immediately, even mid-request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= START;
            pc      <= RESET_PC;
            reqaddr <= RESET_PC;
            ibuf    <= 32'h0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            reqaddr <= reqaddr_next;
            ibuf    <= ibuf_next;
        end
    end

    // Next-state and next-register computation.
    // NOTE: every variable gets a hold default first so no path infers a latch.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        reqaddr_next = reqaddr;
        ibuf_next    = ibuf;
        case (state)
            START: begin
                reqaddr_next = pc;
                state_next   = FETCH;
            end
            FETCH: begin
                if (PCSrcD) begin
                    pc_next = target;
                    if (imem_ready) begin
                        // Data arrived for the old path: drop it and start the new request now.
                        reqaddr_next = target;
                    end else begin
                        // Request must complete first; remember that its data is stale.
                        state_next = DISCARD;
                    end
                end else if (imem_ready) begin
                    ibuf_next  = imem_rdata;
                    state_next = HAVE;
                end
            end
            DISCARD: begin
                // The latest redirect wins while waiting for the stale request.
                if (PCSrcD) begin
                    pc_next = target;
                end
                if (imem_ready) begin
                    reqaddr_next = pc_next;
                    state_next   = FETCH;
                end
            end
            HAVE: begin
                if (PCSrcD) begin
                    pc_next      = target;
                    reqaddr_next = target;
                    state_next   = FETCH;
                end else if (!StallF) begin
                    pc_next      = pc_plus4;
                    reqaddr_next = pc_plus4;
                    state_next   = FETCH;
                end
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem_req  = 1'b0;
        ValidF    = 1'b0;
        FetchBusy = 1'b1;
        instrF    = 32'h0;
        case (state)
            FETCH, DISCARD: begin
                imem_req = 1'b1;
            end
            HAVE: begin
                ValidF    = 1'b1;
                FetchBusy = 1'b0;
                instrF    = ibuf;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = reqaddr;
    assign PcPlus4F  = pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model feeds
// a scoreboard of instructions that must reach decode, plus directed checks
// of the request/redirect/stall/reset behaviour.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcD = 1'b0;
    logic [31:0] PCBranchD = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instrF;
    logic [31:0] PcPlus4F;
    logic        ValidF;
    logic        FetchBusy;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instrF     (instrF),
        .PcPlus4F   (PcPlus4F),
        .ValidF     (ValidF),
        .FetchBusy  (FetchBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    int   mem_lat = 1;
    bit   stale = 1'b0;
    bit   discard = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C22_0004;
        return {a[15:0], 16'hBEEF ^ a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard push/pop before the edge, memory response after it.
    task automatic step();
        logic        req_p, rdy_p, rst_p;
        logic [31:0] addr_p;
        exp_t        e;
        req_p  = imem_req;
        rdy_p  = imem_ready;
        rst_p  = reset;
        addr_p = imem_addr;
        if (!reset && ValidF && (!StallF || PCSrcD)) begin
            check("sb_entry", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_instrF", instrF, e.instr);
                check("sb_PcPlus4F", PcPlus4F, e.pcp4);
            end
        end
        if (!reset && imem_req) begin
            if (imem_ready) begin
                if (!PCSrcD && !discard) sb.push_back('{imem_rdata, addr_p + 32'd4});
                discard = 1'b0;
            end else if (PCSrcD) begin
                discard = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!reset && req_p && !rdy_p && !rst_p) begin
            cnt++;
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, addr_p);
        end else begin
            cnt = 0;
        end
        imem_ready = (imem_req && cnt >= mem_lat - 1) || stale;
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!ValidF && n < budget) begin
            step();
            n++;
        end
        check("valid_timeout", 32'(ValidF), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(ValidF), 32'd0);
        check("rst_instr", instrF, 32'h0);
        check("rst_busy", 32'(FetchBusy), 32'd1);
        check("rst_pcp4", PcPlus4F, RESET_PC + 32'd4);
        reset = 1'b0;
        #1;
        check("start_req", 32'(imem_req), 32'd0);
        check("start_busy", 32'(FetchBusy), 32'd1);
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);

        // Zero-wait streaming: one instruction every two cycles
        for (int i = 0; i < 4; i++) begin
            check("zw_req", 32'(imem_req), 32'd1);
            check("zw_addr", imem_addr, 32'(4 * i));
            check("zw_valid0", 32'(ValidF), 32'd0);
            step();
            check("zw_valid1", 32'(ValidF), 32'd1);
            check("zw_pcp4", PcPlus4F, 32'(4 * (i + 1)));
            check("zw_busy", 32'(FetchBusy), 32'd0);
            check("zw_noreq", 32'(imem_req), 32'd0);
            if (i == 3) mem_lat = 3;
            step();
        end

        // Three-cycle memory at 0x10
        for (int k = 0; k < 3; k++) begin
            check("lat_busy", 32'(FetchBusy), 32'd1);
            check("lat_addr", imem_addr, 32'h10);
            check("lat_valid", 32'(ValidF), 32'd0);
            step();
        end
        check("lat_instr", instrF, 32'h8C22_0004);
        check("lat_pcp4", PcPlus4F, 32'h14);
        check("lat_validF", 32'(ValidF), 32'd1);

        // Stall in HAVE for four cycles
        StallF = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_instr", instrF, 32'h8C22_0004);
            check("stall_pcp4", PcPlus4F, 32'h14);
            check("stall_valid", 32'(ValidF), 32'd1);
            check("stall_noreq", 32'(imem_req), 32'd0);
        end
        StallF = 1'b0;
        step();
        check("unstall_addr", imem_addr, 32'h14);
        check("unstall_req", 32'(imem_req), 32'd1);
        wait_valid(10);
        check("unstall_pcp4", PcPlus4F, 32'h18);

        // Redirect during a pending request at 0x40 (target bits [1:0] ignored)
        mem_lat = 4;
        PCSrcD = 1'b1;
        PCBranchD = 32'h43;
        step();
        PCSrcD = 1'b0;
        check("pend_addr", imem_addr, 32'h40);
        step();
        PCSrcD = 1'b1;
        PCBranchD = 32'h200;
        step();
        PCSrcD = 1'b0;
        check("disc_addr0", imem_addr, 32'h40);
        check("disc_valid0", 32'(ValidF), 32'd0);
        step();
        check("disc_addr1", imem_addr, 32'h40);
        check("disc_valid1", 32'(ValidF), 32'd0);
        step();
        check("disc_newaddr", imem_addr, 32'h200);
        check("disc_valid2", 32'(ValidF), 32'd0);
        wait_valid(10);
        check("disc_pcp4", PcPlus4F, 32'h204);
        check("disc_instr", instrF, mem_word(32'h200));

        // Redirect coincident with imem_ready
        mem_lat = 1;
        step();
        check("co_addr0", imem_addr, 32'h204);
        PCSrcD = 1'b1;
        PCBranchD = 32'h300;
        step();
        PCSrcD = 1'b0;
        check("co_req", 32'(imem_req), 32'd1);
        check("co_addr", imem_addr, 32'h300);
        check("co_valid", 32'(ValidF), 32'd0);
        step();
        check("co_pcp4", PcPlus4F, 32'h304);
        check("co_instr", instrF, mem_word(32'h300));

        // Redirect beats stall in HAVE; latest redirect wins in DISCARD
        mem_lat = 3;
        StallF = 1'b1;
        PCSrcD = 1'b1;
        PCBranchD = 32'h500;
        step();
        StallF = 1'b0;
        PCSrcD = 1'b0;
        check("prio_addr", imem_addr, 32'h500);
        check("prio_valid", 32'(ValidF), 32'd0);
        PCSrcD = 1'b1;
        PCBranchD = 32'h600;
        step();
        PCBranchD = 32'h700;
        step();
        PCSrcD = 1'b0;
        check("latest_hold", imem_addr, 32'h500);
        step();
        check("latest_addr", imem_addr, 32'h700);
        wait_valid(10);
        check("latest_pcp4", PcPlus4F, 32'h704);

        // PC+4 wraps at the top of the address space
        PCSrcD = 1'b1;
        PCBranchD = 32'hFFFF_FFFF;
        step();
        PCSrcD = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(10);
        check("wrap_pcp4", PcPlus4F, 32'h0);
        step();
        check("wrap_next", imem_addr, 32'h0);

        // Reset asserted mid-request at 0x80, stale ready afterwards
        wait_valid(10);
        mem_lat = 4;
        PCSrcD = 1'b1;
        PCBranchD = 32'h80;
        step();
        PCSrcD = 1'b0;
        step();
        check("mid_addr", imem_addr, 32'h80);
        #2;
        reset = 1'b1;
        stale = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_busy", 32'(FetchBusy), 32'd1);
        check("mid_rst_valid", 32'(ValidF), 32'd0);
        check("mid_rst_instr", instrF, 32'h0);
        check("mid_rst_pcp4", PcPlus4F, RESET_PC + 32'd4);
        sb.delete();
        discard = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("post_start_req", 32'(imem_req), 32'd0);
        check("post_start_valid", 32'(ValidF), 32'd0);
        stale = 1'b0;
        step();
        check("post_req", 32'(imem_req), 32'd1);
        check("post_addr", imem_addr, RESET_PC);
        check("post_valid", 32'(ValidF), 32'd0);
        wait_valid(10);
        check("post_pcp4", PcPlus4F, RESET_PC + 32'd4);
        check("post_instr", instrF, mem_word(RESET_PC));
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port StallF  input  1  hazard-unit stall; decode cannot accept the presented instruction this cycle.
REQ-005 SHALL have port PCSrcD  input  1  redirect request from decode (taken branch/jump).
REQ-006 SHALL have port PCBranchD  input  32  redirect target address.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_addr  output  32  instruction-memory word address (byte address, word aligned).
REQ-009 SHALL have port imem_ready  input  1  memory completion strobe; imem_rdata valid in that cycle.
REQ-010 SHALL have port imem_rdata  input  32  instruction word returned by memory.
REQ-011 SHALL have port instrF  output  32  instruction presented to the F/D pipeline register.
REQ-012 SHALL have port PcPlus4F  output  32  address of presented instruction plus 4.
REQ-013 SHALL have port ValidF  output  1  instrF/PcPlus4F hold a real instruction this cycle.
REQ-014 SHALL have port FetchBusy  output  1  fetch waiting on memory; hazard unit stalls/bubbles decode.

Function
REQ-015 SHALL implement states START, FETCH, DISCARD, HAVE; registers pc, reqaddr, ibuf (32 bits each).
REQ-016 SHALL in START: imem_req=0, ValidF=0, FetchBusy=1; next state FETCH with reqaddr<=pc.
REQ-017 SHALL in FETCH and DISCARD: imem_req=1, imem_addr=reqaddr, FetchBusy=1, ValidF=0, instrF=32'h0 (NOP).
REQ-018 SHALL hold imem_req high and imem_addr stable from request start until the imem_ready cycle inclusive; no request abandoned.
REQ-019 SHALL in FETCH, imem_ready=1 and PCSrcD=0: ibuf<=imem_rdata, next HAVE.
REQ-020 SHALL in FETCH, PCSrcD=1 and imem_ready=0: pc<=PCBranchD, next DISCARD.
REQ-021 SHALL in FETCH, PCSrcD=1 and imem_ready=1 same cycle: drop data, pc<=PCBranchD, reqaddr<=PCBranchD, stay FETCH.
REQ-022 SHALL in DISCARD: PCSrcD=1 overwrites pc with PCBranchD (latest wins); on imem_ready drop data, reqaddr<=updated pc, next FETCH.
REQ-023 SHALL in HAVE: imem_req=0, ValidF=1, FetchBusy=0, instrF=ibuf, PcPlus4F=pc+4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-024 SHALL in HAVE, PCSrcD=1 (priority over StallF): pc<=PCBranchD, reqaddr<=PCBranchD, next FETCH, ibuf content discarded.
REQ-025 SHALL in HAVE, PCSrcD=0, StallF=0: pc<=pc+4, reqaddr<=pc+4, next FETCH.
REQ-026 SHALL in HAVE, PCSrcD=0, StallF=1: hold state, pc, ibuf; outputs unchanged.
REQ-027 SHALL drive PcPlus4F=pc+4 in all states; ValidF=0 marks it don't-care outside HAVE.
REQ-028 SHALL ignore imem_ready in START and HAVE.
REQ-029 SHALL ignore bits [1:0] of PCBranchD (forced to 00 on capture).
REQ-030 SHALL give minimum throughput one instruction per 2 cycles (ready in first FETCH cycle, then HAVE).

Reset
REQ-031 SHALL on reset assertion, at any time including mid-request, immediately force state=START, pc=RESET_PC, reqaddr=RESET_PC, ibuf=0.
REQ-032 SHALL while reset high drive imem_req=0, ValidF=0, instrF=0, FetchBusy=1, PcPlus4F=RESET_PC+4.
REQ-033 SHALL issue first request (imem_addr=RESET_PC) in second rising edge after reset deassertion (START then FETCH).

Verification
REQ-034 Zero-wait memory, StallF=0, RESET_PC=0 -> imem_addr sequence 0,4,8,...; ValidF pulses every other cycle with PcPlus4F 4,8,12.
REQ-035 3-cycle-latency memory at addr 0x10 returning 0x8C220004 -> FetchBusy=1 for 3 cycles, then instrF=0x8C220004, PcPlus4F=0x14, ValidF=1.
REQ-036 HAVE with StallF=1 for 4 cycles -> instrF, PcPlus4F, ValidF constant, imem_req=0; StallF=0 -> next imem_addr=pc+4.
REQ-037 PCSrcD=1, PCBranchD=0x200 in second cycle of pending request at 0x40 -> imem_addr stays 0x40 until ready, data dropped (ValidF stays 0), next imem_addr=0x200.
REQ-038 PCSrcD and imem_ready same cycle, target 0x300 -> returned word never presented; next cycle imem_req=1, imem_addr=0x300.
REQ-039 reset asserted mid-request at 0x80 -> imem_req=0 same cycle; after release first request at RESET_PC; stale imem_ready ignored.
